gpio_port: RTL and testbench

- Parametrised, memory-mapped general-purpose I/O block for the CPU.
- Replaces fixed single-bit and 30-bit pin pairs with NCH channels of WIDTH bits each. Every channel has a synchronised input, an output register with atomic set/clear, and sticky edge detection with a per-bit interrupt enable.
- Sits on the CPU data bus next to data memory; irq feeds the core's external interrupt line.

---
 rtl/gpio_port.sv | 171 +++++++++++++++++
 tb/tb_gpio_port.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
`default_nettype none
// ============================================================================
// Module   : gpio_port
// Brief    : Memory-mapped GPIO block with NCH channels of WIDTH bits each.
//            Every channel has a synchronised input, an output register with
//            atomic set/clear, and sticky, polarity-selectable edge detection
//            with a per-bit interrupt enable.
// Ports    : clk, rst (async active-high) ; sel/we/addr/wdata bus request ;
//            rdata/rvalid read response (1-cycle latency) ;
//            gpio_in (async pins), gpio_out (registered pins) ; irq (level).
// Address  : addr = {channel, reg[2:0]}
//            reg 0 IN(ro) 1 OUT(rw) 2 SET(wo) 3 CLR(wo) 4 EDGE(w1c)
//                5 IE(rw) 6 POL(rw, 1 = falling) 7 reserved
// Revision : 1.0 - initial release
// ============================================================================
module gpio_port #(
    parameter int          NCH       = 2,
    parameter int          WIDTH     = 30,
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] OUT_RESET = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sel,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   rvalid,
    input  logic [NCH*WIDTH-1:0]   gpio_in,
    output logic [NCH*WIDTH-1:0]   gpio_out,
    output logic                   irq
);

    localparam int         CH_W       = ADDR_W - 3;
    localparam logic [2:0] c_REG_IN   = 3'd0;
    localparam logic [2:0] c_REG_OUT  = 3'd1;
    localparam logic [2:0] c_REG_SET  = 3'd2;
    localparam logic [2:0] c_REG_CLR  = 3'd3;
    localparam logic [2:0] c_REG_EDGE = 3'd4;
    localparam logic [2:0] c_REG_IE   = 3'd5;
    localparam logic [2:0] c_REG_POL  = 3'd6;

    logic [CH_W-1:0] w_ch_idx;
    logic [2:0]      w_reg;
    logic            w_wr;
    logic            w_rd;

    assign w_ch_idx = addr[ADDR_W-1:3];
    assign w_reg    = addr[2:0];
    assign w_wr     = sel & we;
    assign w_rd     = sel & ~we;

    // Bits of wdata above WIDTH are deliberately ignored.
    logic w_unused;
    assign w_unused = &{1'b0, wdata};

    // Per-channel read value (already zero when the channel is not addressed)
    // and per-channel interrupt request.
    logic [31:0]    w_rd_vec [NCH];
    logic [NCH-1:0] w_irq_vec;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic             w_hit;
            logic [WIDTH-1:0] w_wdat;
            logic [WIDTH-1:0] r_out,  w_out_nxt;
            logic [WIDTH-1:0] r_ie,   w_ie_nxt;
            logic [WIDTH-1:0] r_pol,  w_pol_nxt;
            logic [WIDTH-1:0] r_edge, w_edge_nxt;
            logic [WIDTH-1:0] r_s1, r_s2, r_s3;
            logic [WIDTH-1:0] w_detect;
            logic [WIDTH-1:0] w_clr;
            logic [31:0]      w_rd_val;

            // Channel indices >= NCH never match, so such accesses fall
            // through to a zero read and an ignored write.
            assign w_hit  = (w_ch_idx == CH_W'(c));
            assign w_wdat = wdata[WIDTH-1:0];

            always_comb begin
                w_out_nxt = r_out;
                w_ie_nxt  = r_ie;
                w_pol_nxt = r_pol;
                w_clr     = '0;
                if (w_wr && w_hit) begin
                    case (w_reg)
                        c_REG_OUT:  w_out_nxt = w_wdat;
                        c_REG_SET:  w_out_nxt = r_out | w_wdat;
                        c_REG_CLR:  w_out_nxt = r_out & ~w_wdat;
                        c_REG_EDGE: w_clr     = w_wdat;
                        c_REG_IE:   w_ie_nxt  = w_wdat;
                        c_REG_POL:  w_pol_nxt = w_wdat;
                        default:    ;
                    endcase
                end

                // Edge seen between s3 (older) and s2 (newer); a detect in the
                // same cycle as a write-1-to-clear keeps the bit set.
                w_detect   = (r_pol & r_s3 & ~r_s2) | (~r_pol & r_s2 & ~r_s3);
                w_edge_nxt = (r_edge & ~w_clr) | w_detect;

                w_rd_val = '0;
                case (w_reg)
                    c_REG_IN:   w_rd_val[WIDTH-1:0] = r_s2;
                    c_REG_OUT:  w_rd_val[WIDTH-1:0] = r_out;
                    c_REG_EDGE: w_rd_val[WIDTH-1:0] = r_edge;
                    c_REG_IE:   w_rd_val[WIDTH-1:0] = r_ie;
                    c_REG_POL:  w_rd_val[WIDTH-1:0] = r_pol;
                    default:    w_rd_val            = '0;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out  <= OUT_RESET[WIDTH-1:0];
                    r_ie   <= '0;
                    r_pol  <= '0;
                    r_edge <= '0;
                    r_s1   <= '0;
                    r_s2   <= '0;
                    r_s3   <= '0;
                end else begin
                    r_out  <= w_out_nxt;
                    r_ie   <= w_ie_nxt;
                    r_pol  <= w_pol_nxt;
                    r_edge <= w_edge_nxt;
                    r_s1   <= gpio_in[c*WIDTH +: WIDTH];
                    r_s2   <= r_s1;
                    r_s3   <= r_s2;
                end
            end

            assign gpio_out[c*WIDTH +: WIDTH] = r_out;
            assign w_rd_vec[c]                = w_hit ? w_rd_val : 32'h0;
            assign w_irq_vec[c]               = |(r_edge & r_ie);
        end
    endgenerate

    logic [31:0] r_rdata, w_rdata_nxt;
    logic        r_rvalid;
    logic        r_irq, w_irq_nxt;

    always_comb begin
        w_rdata_nxt = '0;
        if (w_rd) begin
            for (int i = 0; i < NCH; i++) begin
                w_rdata_nxt = w_rdata_nxt | w_rd_vec[i];
            end
        end
        w_irq_nxt = |w_irq_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_rdata  <= w_rdata_nxt;
            r_rvalid <= w_rd;
            r_irq    <= w_irq_nxt;
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign irq    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_port
// Brief    : Directed self-checking bench for gpio_port (NCH=2, WIDTH=30).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_port;

    localparam int NCH    = 2;
    localparam int WIDTH  = 30;
    localparam int ADDR_W = 6;

    logic                  clk;
    logic                  rst;
    logic                  sel;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  rvalid;
    logic [NCH*WIDTH-1:0]  gpio_in;
    logic [NCH*WIDTH-1:0]  gpio_out;
    logic                  irq;

    int n_checks = 0;
    int n_errors = 0;

    gpio_port #(
        .NCH       (NCH),
        .WIDTH     (WIDTH),
        .ADDR_W    (ADDR_W),
        .OUT_RESET (32'h0)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] ch, input logic [2:0] rg, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = {ch, rg};
        wdata = d;
        tick();
        sel   = 1'b0;
        we    = 1'b0;
        wdata = 32'h0;
    endtask

    task automatic bus_read(input string tag, input logic [2:0] ch, input logic [2:0] rg,
                            input logic [31:0] exp);
        sel  = 1'b1;
        we   = 1'b0;
        addr = {ch, rg};
        tick();
        chk({tag, " rvalid"}, {63'h0, rvalid}, 64'h1);
        chk(tag, {32'h0, rdata}, {32'h0, exp});
        sel  = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        sel     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = 32'h0;
        gpio_in = '0;
        gpio_in[29:0] = 30'h2100_0000;

        // Reset state
        #1;
        chk("reset gpio_out", {4'h0, gpio_out}, 64'h0);
        chk("reset irq",      {63'h0, irq},     64'h0);
        chk("reset rvalid",   {63'h0, rvalid},  64'h0);
        chk("reset rdata",    {32'h0, rdata},   64'h0);
        tick(2);
        rst = 1'b0;
        tick(3);
        bus_read("ch0 IN", 3'd0, 3'd0, 32'h2100_0000);
        // The pins rising after reset release are captured as edges.
        bus_read("ch0 EDGE initial", 3'd0, 3'd4, 32'h2100_0000);
        bus_write(3'd0, 3'd4, 32'h3FFF_FFFF);
        bus_read("ch0 EDGE cleared", 3'd0, 3'd4, 32'h0);
        tick();
        chk("rvalid idle", {63'h0, rvalid}, 64'h0);
        chk("rdata idle",  {32'h0, rdata},  64'h0);

        // OUT / SET / CLR on channel 1
        bus_write(3'd1, 3'd1, 32'h3FFF_0000);
        chk("ch1 OUT immediate", {4'h0, gpio_out}, {4'h0, 30'h3FFF_0000, 30'h0});
        bus_write(3'd1, 3'd2, 32'h0000_00FF);
        bus_write(3'd1, 3'd3, 32'h00FF_0000);
        chk("ch1 gpio_out", {34'h0, gpio_out[59:30]}, 64'h3F00_00FF);
        chk("ch0 gpio_out", {34'h0, gpio_out[29:0]},  64'h0);
        bus_read("ch1 OUT", 3'd1, 3'd1, 32'h3F00_00FF);

        // Rising edge on ch0 bit0 with IE enabled
        bus_write(3'd0, 3'd5, 32'h1);
        bus_write(3'd0, 3'd6, 32'h0);
        gpio_in[0] = 1'b1;               // settles before edge k
        tick(3);                         // k, k+1, k+2
        chk("irq at k+2", {63'h0, irq}, 64'h0);
        tick();                          // k+3
        chk("irq at k+3", {63'h0, irq}, 64'h1);
        bus_read("ch0 EDGE bit0", 3'd0, 3'd4, 32'h1);
        bus_write(3'd0, 3'd4, 32'h1);
        chk("irq after W1C edge", {63'h0, irq}, 64'h1);
        tick();
        chk("irq one cycle after W1C", {63'h0, irq}, 64'h0);

        // Falling edge with POL=1 re-arms EDGE[0]; then a rising edge is
        // detected in the same cycle as a W1C of that bit.
        bus_write(3'd0, 3'd6, 32'h1);
        gpio_in[0] = 1'b0;
        tick(4);
        chk("irq after falling edge", {63'h0, irq}, 64'h1);
        bus_write(3'd0, 3'd6, 32'h0);    // pin static: no detect from POL change
        gpio_in[0] = 1'b1;
        tick(2);                         // m, m+1: detect active this cycle
        bus_write(3'd0, 3'd4, 32'h1);    // W1C sampled at m+2
        chk("irq during W1C collision", {63'h0, irq}, 64'h1);
        tick();
        chk("irq after W1C collision", {63'h0, irq}, 64'h1);
        bus_read("ch0 EDGE after collision", 3'd0, 3'd4, 32'h1);
        bus_write(3'd0, 3'd4, 32'h1);
        tick();
        chk("irq after plain W1C", {63'h0, irq}, 64'h0);

        // Falling-edge polarity on ch1 bit5 (IE on ch1 is 0)
        bus_write(3'd1, 3'd6, 32'h20);
        gpio_in[35] = 1'b1;
        tick(4);
        bus_read("ch1 EDGE after rise", 3'd1, 3'd4, 32'h0);
        gpio_in[35] = 1'b0;
        tick(4);
        bus_read("ch1 EDGE after fall", 3'd1, 3'd4, 32'h20);
        chk("irq ch1 IE off", {63'h0, irq}, 64'h0);

        // Out-of-range channel, reserved and write-only registers
        bus_read("ch2 IN", 3'd2, 3'd0, 32'h0);
        bus_read("ch0 reg7", 3'd0, 3'd7, 32'h0);
        bus_read("ch1 SET read", 3'd1, 3'd2, 32'h0);
        bus_write(3'd2, 3'd1, 32'h1234_5678);
        bus_write(3'd0, 3'd7, 32'h1234_5678);
        chk("gpio_out after ignored writes", {4'h0, gpio_out}, {4'h0, 30'h3F00_00FF, 30'h0});

        // Reset in the middle of a read access
        sel  = 1'b1;
        we   = 1'b0;
        addr = {3'd1, 3'd1};
        #2;
        rst = 1'b1;
        sel = 1'b0;
        #1;
        chk("midreset gpio_out", {4'h0, gpio_out}, 64'h0);
        chk("midreset irq",      {63'h0, irq},     64'h0);
        chk("midreset rvalid",   {63'h0, rvalid},  64'h0);
        chk("midreset rdata",    {32'h0, rdata},   64'h0);
        #1;
        rst = 1'b0;
        tick();
        chk("no rvalid after reset", {63'h0, rvalid}, 64'h0);
        bus_read("ch1 OUT after reset", 3'd1, 3'd1, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
